multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle RV32I control unit for a shared-memory, single-port datapath.
- A sequential FSM walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives all datapath selects and write enables.
- Handshakes with instruction/data memory, resolves branches from the comparator flags and traps on illegal opcodes or memory timeout.
- Sits between the instruction register/comparator and the PC, register file, ALU, immediate generator and memory.

Parameters:
- XLEN, 32, instruction/datapath width; only instr[31:0] is decoded.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  XLEN  current instruction from the IR (valid from DECODE onward).
- mem_ready  in  1  memory completes the current request this cycle.
- br_eq  in  1  comparator rs1==rs2.
- br_lt  in  1  comparator rs1<rs2, signedness per br_un.
- ir_we  out  1  load the IR from memory read data.
- pc_we  out  1  update the PC.
- pc_sel  out  1  0 = PC+4, 1 = ALU result.
- reg_wen  out  1  register file write.
- imm_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- alu_src1  out  1  0 = rs1, 1 = PC.
- alu_src2  out  1  0 = rs2, 1 = immediate.
- alu_sel  out  4  {funct7[5],funct3}; ADD=0000; PASSB=1111.
- br_un  out  1  unsigned compare (funct3[1]).
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  store; 0 = read.
- ld_u  out  1  zero-extend load (funct3[2]).
- wb_sel  out  2  0 = mem, 1 = alu, 2 = PC+4.
- instr_done  out  1  one-cycle pulse on the commit cycle.
- illegal  out  1  sticky illegal-instruction flag.
- bus_err  out  1  sticky memory-timeout flag.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset: while rst=1, every output is 0 and state=FETCH. The first cycle after rst falls is FETCH.
- FETCH:
  - Drives mem_req=1, mem_we=0.
  - On mem_ready, drives ir_we=1 and goes to DECODE. Otherwise it stays in FETCH.
- DECODE: lasts one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Also illegal: B-type funct3 010 or 011.
  - Any other opcode sets illegal and goes to TRAP. Otherwise go to EXECUTE.
- Decoded fields are held constant from DECODE through commit: imm_sel, alu_src1/2, alu_sel, br_un, ld_u, wb_sel.
- alu_sel by instruction type:
  - R-type: {f7[5],f3}.
  - I-ALU: {f7[5]&(f3==101),f3}.
  - LUI: PASSB.
  - Load, store, branch, JAL, JALR, AUIPC: ADD.
- alu_src1=1 (PC) for branch, JAL and AUIPC. alu_src2=1 (immediate) for everything except R-type.
- EXECUTE:
  - Branch: pc_we=1, instr_done=1, then FETCH.
  - Branch taken is decided from br_eq/br_lt and funct3 (beq, bne, blt, bge, bltu, bgeu) and drives pc_sel=taken.
  - Load/store go to MEM. All other instructions go to WRITEBACK.
- MEM:
  - Drives mem_req=1, with mem_we=1 for stores.
  - On mem_ready, a store commits (pc_we=1, pc_sel=0, instr_done=1, then FETCH). A load goes to WRITEBACK.
- WRITEBACK:
  - reg_wen=1, pc_we=1, instr_done=1, then FETCH.
  - pc_sel=1 for JAL/JALR, else 0. wb_sel=2 for JAL/JALR, 0 for loads, 1 otherwise.
- TRAP:
  - All enables and mem_req are 0. TRAP is held until rst.
  - illegal and bus_err are sticky and cleared only by rst.
- Timeout:
  - wait_cnt (width $clog2(MEM_TIMEOUT+1)) clears on entry to FETCH/MEM and increments each cycle that mem_req=1 and mem_ready=0.
  - If wait_cnt==MEM_TIMEOUT and mem_ready=0, set bus_err and go to TRAP.
  - mem_ready in that same cycle wins over the timeout.
- Latency with zero wait states (mem_ready on the first request cycle):
  - Branch: 3 cycles.
  - R/I/U/J and store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- Boundaries:
  - mem_ready outside FETCH/MEM is ignored.
  - rst mid-instruction aborts it with no commit.
  - x0 writes are suppressed by the register file, not here.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - IMM_I..IMM_J;
  - ALU_ADD, ALU_PASSB;
  - WB_MEM, WB_ALU, WB_PC4;
  - FSM state encoding (FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5).
- Sub-module ctrl_decode: combinational; maps instr to field selects, a legal flag and an instruction-class flag. multicycle_control owns the FSM, the timeout counter and enable gating.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset; cycle 1 shows state=0, mem_req=1, ir_we=1.
- add x3,x1,x2 (0x002081B3), zero wait -> DECODE/EXECUTE/WRITEBACK follow; WB cycle shows alu_sel=0000, wb_sel=1, reg_wen=1, pc_we=1, instr_done=1; 4 cycles total.
- beq taken/not (0x00208463) with br_eq=1, then 0 -> EXECUTE pc_we=1 with pc_sel=1, then 0; imm_sel=2; 3 cycles each.
- lw (0x0000A183) with mem_ready delayed 2 cycles in MEM -> mem_req held 3 cycles, mem_we=0, then WRITEBACK with wb_sel=0; 7 cycles total.
- sw, with mem_ready never asserted, MEM_TIMEOUT=15 -> bus_err=1 after 16 request cycles, state=5 held; rst clears it.
- opcode 0x0000007F, then jal x1 (0x008000EF) after reset -> first gives illegal=1 and TRAP; second gives WB with wb_sel=2, pc_sel=1, alu_src1=1, imm_sel=4.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and decoded-field bundle
// for the multi-cycle RV32I control unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP
    } iclass_e;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       alu_src1;
        logic       alu_src2;
        logic [3:0] alu_sel;
        logic       br_un;
        logic       ld_u;
        logic [1:0] wb_sel;
    } dec_t;

    // funct3[2] picks lt vs eq, funct3[0] inverts the sense
    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic       eq,
                                      input logic       lt);
        return f3[2] ? (lt ^ f3[0]) : (eq ^ f3[0]);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: datapath selects,
// legality and instruction class from opcode/funct fields.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output dec_t       fields,
    output logic       legal,
    output iclass_e    iclass
);

    always_comb begin
        fields.imm_sel  = IMM_I;
        fields.alu_src1 = 1'b0;
        fields.alu_src2 = 1'b1;
        fields.alu_sel  = ALU_ADD;
        fields.br_un    = 1'b0;
        fields.ld_u     = 1'b0;
        fields.wb_sel   = WB_ALU;
        legal           = 1'b1;
        iclass          = CL_ALU;
        case (opcode)
            OP_R: begin
                fields.alu_src2 = 1'b0;
                fields.alu_sel  = {funct7_5, funct3};
            end
            OP_I: begin
                // only srai uses bit 30; addi etc. carry immediate bits there
                fields.alu_sel = {funct7_5 & (funct3 == 3'b101), funct3};
            end
            OP_LOAD: begin
                iclass        = CL_LOAD;
                fields.ld_u   = funct3[2];
                fields.wb_sel = WB_MEM;
            end
            OP_STORE: begin
                iclass         = CL_STORE;
                fields.imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                iclass          = CL_BRANCH;
                fields.imm_sel  = IMM_B;
                fields.alu_src1 = 1'b1;
                fields.br_un    = funct3[1];
                legal           = (funct3[2:1] != 2'b01);
            end
            OP_JAL: begin
                iclass          = CL_JUMP;
                fields.imm_sel  = IMM_J;
                fields.alu_src1 = 1'b1;
                fields.wb_sel   = WB_PC4;
            end
            OP_JALR: begin
                iclass        = CL_JUMP;
                fields.wb_sel = WB_PC4;
            end
            OP_LUI: begin
                fields.imm_sel = IMM_U;
                fields.alu_sel = ALU_PASSB;
            end
            OP_AUIPC: begin
                fields.imm_sel  = IMM_U;
                fields.alu_src1 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/
// writeback sequencing, memory handshake timeout and traps.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic            mem_ready,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            reg_wen,
    output logic [2:0]      imm_sel,
    output logic            alu_src1,
    output logic            alu_src2,
    output logic [3:0]      alu_sel,
    output logic            br_un,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ld_u,
    output logic [1:0]      wb_sel,
    output logic            instr_done,
    output logic            illegal,
    output logic            bus_err,
    output logic [2:0]      state
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    dec_t            dec;
    logic            legal;
    iclass_e         iclass;
    logic            timeout;

    logic            req, we, irw, pcw, pcs, rwe, done, fen;

    logic            unused_bits;
    assign unused_bits = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

    ctrl_decode u_dec (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .fields   (dec),
        .legal    (legal),
        .iclass   (iclass)
    );

    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready
                  && (wait_q == CW'(MEM_TIMEOUT));

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        req  = 1'b0;
        we   = 1'b0;
        irw  = 1'b0;
        pcw  = 1'b0;
        pcs  = 1'b0;
        rwe  = 1'b0;
        done = 1'b0;
        fen  = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    irw     = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            DECODE: begin
                fen = 1'b1;
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                fen = 1'b1;
                if (iclass == CL_BRANCH) begin
                    pcw     = 1'b1;
                    pcs     = br_taken(instr[14:12], br_eq, br_lt);
                    done    = 1'b1;
                    state_d = FETCH;
                end else if (iclass == CL_LOAD || iclass == CL_STORE) begin
                    state_d = MEM;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                fen = 1'b1;
                req = 1'b1;
                we  = (iclass == CL_STORE);
                if (mem_ready) begin
                    if (iclass == CL_STORE) begin
                        pcw     = 1'b1;
                        done    = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            WRITEBACK: begin
                fen     = 1'b1;
                rwe     = 1'b1;
                pcw     = 1'b1;
                pcs     = (iclass == CL_JUMP);
                done    = 1'b1;
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase
        // every request phase starts with a zero count
        wait_d = (req && !mem_ready) ? wait_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ir_we      = !rst && irw;
    assign pc_we      = !rst && pcw;
    assign pc_sel     = !rst && pcs;
    assign reg_wen    = !rst && rwe;
    assign mem_req    = !rst && req;
    assign mem_we     = !rst && we;
    assign instr_done = !rst && done;
    assign illegal    = !rst && illegal_q;
    assign bus_err    = !rst && bus_err_q;
    assign state      = rst ? 3'(FETCH) : 3'(state_q);

    assign {imm_sel, alu_src1, alu_src2, alu_sel, br_un, ld_u, wb_sel} =
        (!rst && fen) ? dec : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table plus random
// instruction stream checked cycle by cycle against a model.
module tb_multicycle_control;

    localparam int TMO = 15;

    localparam logic [8:0] O_REQ = 9'h100;
    localparam logic [8:0] O_WE  = 9'h080;
    localparam logic [8:0] O_IR  = 9'h040;
    localparam logic [8:0] O_PW  = 9'h020;
    localparam logic [8:0] O_PS  = 9'h010;
    localparam logic [8:0] O_RW  = 9'h008;
    localparam logic [8:0] O_DN  = 9'h004;
    localparam logic [8:0] O_IL  = 9'h002;
    localparam logic [8:0] O_BE  = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;
    logic        ir_we, pc_we, pc_sel, reg_wen;
    logic [2:0]  imm_sel;
    logic        alu_src1, alu_src2;
    logic [3:0]  alu_sel;
    logic        br_un, mem_req, mem_we, ld_u;
    logic [1:0]  wb_sel;
    logic        instr_done, illegal, bus_err;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .br_eq(br_eq), .br_lt(br_lt), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .reg_wen(reg_wen), .imm_sel(imm_sel),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_sel(alu_sel),
        .br_un(br_un), .mem_req(mem_req), .mem_we(mem_we), .ld_u(ld_u),
        .wb_sel(wb_sel), .instr_done(instr_done), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    // cls: 0 alu, 1 load, 2 store, 3 branch, 4 jump
    typedef struct packed {
        logic       legal;
        logic [2:0] cls;
        logic [2:0] imm;
        logic       s1;
        logic       s2;
        logic [3:0] alu;
        logic       bun;
        logic       ldu;
        logic [1:0] wb;
        logic       imm_dc;
    } fexp_t;

    typedef struct packed {
        logic       rdy;
        logic [2:0] st;
        logic [8:0] o;
        logic       chkf;
    } step_t;

    typedef struct {
        logic [31:0] in;
        logic        eq;
        logic        lt;
        int          fw;
        int          mw;
        int          cyc;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic        pcs;
        logic [1:0]  fl;
    } vec_t;

    step_t q[$];
    fexp_t cur;

    function automatic fexp_t model(input logic [31:0] in);
        fexp_t e;
        logic [2:0] f3;
        f3 = in[14:12];
        e = '0;
        e.legal = 1'b1;
        e.s2 = 1'b1;
        e.wb = 2'd1;
        case (in[6:0])
            7'b0110011: begin
                e.s2 = 1'b0;
                e.alu = {in[30], f3};
                e.imm_dc = 1'b1;
            end
            7'b0010011: e.alu = {in[30] && f3 == 3'd5, f3};
            7'b0000011: begin e.cls = 3'd1; e.wb = 2'd0; e.ldu = f3[2]; end
            7'b0100011: begin e.cls = 3'd2; e.imm = 3'd1; end
            7'b1100011: begin
                e.cls = 3'd3; e.imm = 3'd2; e.s1 = 1'b1; e.bun = f3[1];
                e.legal = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'b1101111: begin e.cls = 3'd4; e.imm = 3'd4; e.s1 = 1'b1; e.wb = 2'd2; end
            7'b1100111: begin e.cls = 3'd4; e.wb = 2'd2; end
            7'b0110111: begin e.imm = 3'd3; e.alu = 4'hF; end
            7'b0010111: begin e.imm = 3'd3; e.s1 = 1'b1; end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic model_taken(input logic [2:0] f3,
                                         input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            default: return !lt;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [2:0] st, input logic rdy,
                                 input logic [8:0] o, input logic chkf);
        q.push_back({rdy, st, o, chkf});
    endfunction

    function automatic void push_trap(input logic [8:0] fl);
        for (int i = 0; i < 3; i++) push(3'd5, rnd(), fl, 1'b0);
    endfunction

    function automatic void build(input logic [31:0] in, input logic eq,
                                  input logic lt, input int fw, input int mw);
        logic       tk;
        logic [8:0] wo;
        cur = model(in);
        tk = model_taken(in[14:12], eq, lt);
        q.delete();
        if (fw > TMO) begin
            for (int i = 0; i <= TMO; i++) push(3'd0, 1'b0, O_REQ, 1'b0);
            push_trap(O_BE);
            return;
        end
        for (int i = 0; i < fw; i++) push(3'd0, 1'b0, O_REQ, 1'b0);
        push(3'd0, 1'b1, O_REQ | O_IR, 1'b0);
        if (!cur.legal) begin
            push(3'd1, rnd(), 9'h0, 1'b0);
            push_trap(O_IL);
            return;
        end
        push(3'd1, rnd(), 9'h0, 1'b1);
        if (cur.cls == 3'd3) begin
            push(3'd2, rnd(), O_PW | O_DN | (tk ? O_PS : 9'h0), 1'b1);
            return;
        end
        push(3'd2, rnd(), 9'h0, 1'b1);
        if (cur.cls == 3'd1 || cur.cls == 3'd2) begin
            wo = (cur.cls == 3'd2) ? O_WE : 9'h0;
            if (mw > TMO) begin
                for (int i = 0; i <= TMO; i++) push(3'd3, 1'b0, O_REQ | wo, 1'b1);
                push_trap(O_BE);
                return;
            end
            for (int i = 0; i < mw; i++) push(3'd3, 1'b0, O_REQ | wo, 1'b1);
            if (cur.cls == 3'd2) begin
                push(3'd3, 1'b1, O_REQ | O_WE | O_PW | O_DN, 1'b1);
                return;
            end
            push(3'd3, 1'b1, O_REQ, 1'b1);
        end
        push(3'd4, rnd(), O_RW | O_PW | O_DN | ((cur.cls == 3'd4) ? O_PS : 9'h0), 1'b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t instr=%h)",
                     name, act, exp, $time, instr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_ready = rnd();
            @(negedge clk);
            chk("reset_outputs", 32'({ir_we, pc_we, pc_sel, reg_wen, imm_sel,
                alu_src1, alu_src2, alu_sel, br_un, mem_req, mem_we, ld_u,
                wb_sel, instr_done, illegal, bus_err, state}), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic run(input logic [31:0] in, input logic eq, input logic lt,
                       input int fw, input int mw, output int cyc,
                       output logic [3:0] alu_c, output logic [1:0] wb_c,
                       output logic pcs_c, output logic [1:0] fl);
        logic [12:0] fm, fa, fx;
        instr = in;
        br_eq = eq;
        br_lt = lt;
        build(in, eq, lt, fw, mw);
        cyc = -1;
        alu_c = 4'h0;
        wb_c = 2'h0;
        pcs_c = 1'b0;
        fl = 2'b00;
        fm = {cur.imm_dc ? 3'b000 : 3'b111, 1'b1, 1'b1, 4'hF,
              cur.cls == 3'd3, cur.cls == 3'd1, 2'b11};
        fx = {cur.imm, cur.s1, cur.s2, cur.alu, cur.bun, cur.ldu, cur.wb};
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = q[i].rdy;
            @(negedge clk);
            chk($sformatf("ctrl_step%0d", i),
                32'({state, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_wen,
                     instr_done, illegal, bus_err}),
                32'({q[i].st, q[i].o}));
            if (q[i].chkf) begin
                fa = {imm_sel, alu_src1, alu_src2, alu_sel, br_un, ld_u, wb_sel};
                chk($sformatf("fields_step%0d", i), 32'(fa & fm), 32'(fx & fm));
            end
            if (cyc < 0) begin
                if (instr_done) begin
                    cyc = i + 1;
                    alu_c = alu_sel;
                    wb_c = wb_sel;
                    pcs_c = pc_sel;
                end else if (state == 3'd5) begin
                    cyc = i;
                end
            end
            fl = {illegal, bus_err};
            @(posedge clk);
            #1;
        end
        if (q[q.size()-1].st == 3'd5) do_reset();
    endtask

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            6: return 7'b1100111;
            7: return 7'b0110111;
            8: return 7'b0010111;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(14, 17));
        return int'($urandom_range(0, 2));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[21];
        int          cyc;
        logic [3:0]  alu_c;
        logic [1:0]  wb_c, fl;
        logic        pcs_c;
        logic [31:0] r;

        tbl[0]  = '{32'h002081B3, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[1]  = '{32'h00208463, 1'b1, 1'b0, 0, 0, 3, 4'h0, 2'd1, 1'b1, 2'b00};
        tbl[2]  = '{32'h00208463, 1'b0, 1'b0, 0, 0, 3, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[3]  = '{32'h0000A183, 1'b0, 1'b0, 0, 2, 7, 4'h0, 2'd0, 1'b0, 2'b00};
        tbl[4]  = '{32'h0020A023, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[5]  = '{32'h0020A023, 1'b0, 1'b0, 0, 99, 19, 4'h0, 2'd0, 1'b0, 2'b01};
        tbl[6]  = '{32'h0000007F, 1'b0, 1'b0, 0, 0, 2, 4'h0, 2'd0, 1'b0, 2'b10};
        tbl[7]  = '{32'h008000EF, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd2, 1'b1, 2'b00};
        tbl[8]  = '{32'h123452B7, 1'b0, 1'b0, 0, 0, 4, 4'hF, 2'd1, 1'b0, 2'b00};
        tbl[9]  = '{32'h40315093, 1'b0, 1'b0, 0, 0, 4, 4'hD, 2'd1, 1'b0, 2'b00};
        tbl[10] = '{32'h402081B3, 1'b0, 1'b0, 0, 0, 4, 4'h8, 2'd1, 1'b0, 2'b00};
        tbl[11] = '{32'h40008093, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[12] = '{32'h0020E463, 1'b0, 1'b1, 0, 0, 3, 4'h0, 2'd1, 1'b1, 2'b00};
        tbl[13] = '{32'h0020D463, 1'b0, 1'b1, 0, 0, 3, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[14] = '{32'h0020A463, 1'b1, 1'b0, 0, 0, 2, 4'h0, 2'd0, 1'b0, 2'b10};
        tbl[15] = '{32'h0000A183, 1'b0, 1'b0, 15, 0, 20, 4'h0, 2'd0, 1'b0, 2'b00};
        tbl[16] = '{32'h0000A183, 1'b0, 1'b0, 16, 0, 16, 4'h0, 2'd0, 1'b0, 2'b01};
        tbl[17] = '{32'h0000C183, 1'b0, 1'b0, 0, 0, 5, 4'h0, 2'd0, 1'b0, 2'b00};
        tbl[18] = '{32'h000100E7, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd2, 1'b1, 2'b00};
        tbl[19] = '{32'h00001097, 1'b0, 1'b0, 0, 0, 4, 4'h0, 2'd1, 1'b0, 2'b00};
        tbl[20] = '{32'h0020A023, 1'b0, 1'b0, 0, 15, 19, 4'h0, 2'd1, 1'b0, 2'b00};

        do_reset();

        for (int k = 0; k < 21; k++) begin
            run(tbl[k].in, tbl[k].eq, tbl[k].lt, tbl[k].fw, tbl[k].mw,
                cyc, alu_c, wb_c, pcs_c, fl);
            chk($sformatf("tbl%0d_cycles", k), 32'(cyc), 32'(tbl[k].cyc));
            chk($sformatf("tbl%0d_flags", k), 32'(fl), 32'(tbl[k].fl));
            if (tbl[k].fl == 2'b00) begin
                chk($sformatf("tbl%0d_alu_sel", k), 32'(alu_c), 32'(tbl[k].alu));
                chk($sformatf("tbl%0d_wb_sel", k), 32'(wb_c), 32'(tbl[k].wb));
                chk($sformatf("tbl%0d_pc_sel", k), 32'(pcs_c), 32'(tbl[k].pcs));
            end
        end

        // reset in EXECUTE of a taken branch must suppress the commit
        instr = 32'h00208463;
        br_eq = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_fetch", 32'({state, ir_we}), 32'({3'd0, 1'b1}));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_decode", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        run(32'h002081B3, 1'b0, 1'b0, 0, 0, cyc, alu_c, wb_c, pcs_c, fl);
        chk("after_abort_cycles", 32'(cyc), 32'd4);

        for (int n = 0; n < 200; n++) begin
            r = $urandom();
            r[6:0] = pick_op(int'($urandom_range(0, 9)));
            run(r, rnd(), rnd(), pick_wait(), pick_wait(),
                cyc, alu_c, wb_c, pcs_c, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
